poly1305_block_sequencer: RTL and testbench

//  Sequences the shared Poly1305 multiplier (mult_130x128_limb) and reducer (reduce_mod_poly1305)

---
 rtl/poly1305_pkg.sv | 31 +++
 rtl/poly1305_block_fmt.sv | 28 ++
 rtl/poly1305_block_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_poly1305_block_sequencer.sv | 457 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/poly1305_pkg.sv
// Shared constants, state encoding and helpers for the Poly1305 block sequencer.
package poly1305_pkg;

  // Prime modulus 2^130 - 5
  localparam logic [129:0] P130    = 130'h3_ffffffff_ffffffff_ffffffff_fffffffb;
  // r clamp mask applied to the raw r key
  localparam logic [127:0] R_CLAMP = 128'h0ffffffc_0ffffffc_0ffffffc_0fffffff;
  // High bit appended to every padded 16-byte block
  localparam logic [128:0] HIBIT   = {1'b1, 128'h0};

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCEPT = 3'd1,
    ST_ADD    = 3'd2,
    ST_MUL    = 3'd3,
    ST_RED    = 3'd4,
    ST_LENBLK = 3'd5,
    ST_FINAL  = 3'd6
  } state_t;

  // Number of set byte enables in a beat
  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = 5'd0;
    for (int i = 0; i < 16; i++) begin
      c = c + {4'd0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/poly1305_block_fmt.sv
// Block formatter: zeroes disabled bytes, inserts the 2^128 pad bit,
// counts enabled bytes and builds the trailing length block.
module poly1305_block_fmt (
  input  logic [127:0] data,
  input  logic [15:0]  keep,
  input  logic [63:0]  aad_bytes,
  input  logic [63:0]  pld_bytes,
  output logic [128:0] beat_m,
  output logic [128:0] len_m,
  output logic [4:0]   keep_cnt
);
  import poly1305_pkg::*;

  logic [127:0] mask_s;

  // Expand per-byte enables into a bit mask
  always_comb begin
    mask_s = 128'h0;
    for (int i = 0; i < 16; i++) begin
      mask_s[i*8 +: 8] = {8{keep[i]}};
    end
  end

  assign beat_m   = {1'b0, data & mask_s} | HIBIT;
  assign len_m    = {1'b0, pld_bytes, aad_bytes} | HIBIT;
  assign keep_cnt = popcount16(keep);

endmodule

// File: rtl/poly1305_block_sequencer.sv
// Poly1305 AEAD block sequencer: accepts AAD/payload beats, drives the external
// multiplier and reducer for h = (h + m) * r mod p, appends the length block
// and produces tag = (h + s) mod 2^128.
module poly1305_block_sequencer #(
  parameter int LEN_W = 64
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [127:0] r_key,
  input  logic [127:0] s_key,
  input  logic         in_valid,
  input  logic [127:0] in_data,
  input  logic [15:0]  in_keep,
  input  logic         in_is_aad,
  input  logic         in_last,
  output logic         in_ready,
  output logic         mul_start,
  output logic [129:0] mul_a,
  output logic [127:0] mul_b,
  input  logic [257:0] mul_product,
  input  logic         mul_done,
  output logic         red_start,
  output logic [257:0] red_value,
  input  logic [129:0] red_result,
  input  logic         red_done,
  output logic [127:0] tag,
  output logic         tag_valid,
  output logic         busy,
  output logic         err
);
  import poly1305_pkg::*;

  state_t             state_r;
  logic [129:0]       h_r;
  logic [127:0]       r_r;
  logic [127:0]       s_r;
  logic [LEN_W-1:0]   aad_bytes_r;
  logic [LEN_W-1:0]   pld_bytes_r;
  logic               pld_seen_r;
  logic               blk_last_r;
  logic               len_blk_r;
  logic [128:0]       m_r;
  logic               in_ready_r;
  logic               mul_start_r;
  logic [129:0]       mul_a_r;
  logic               red_start_r;
  logic [257:0]       red_value_r;
  logic [127:0]       tag_r;
  logic               tag_valid_r;
  logic               busy_r;
  logic               err_r;

  logic [128:0]       beat_m_s;
  logic [128:0]       len_m_s;
  logic [4:0]         keep_cnt_s;
  logic [LEN_W-1:0]   keep_ext_s;
  logic [130:0]       sum_s;
  logic [129:0]       fold_s;
  logic [127:0]       h_low_s;
  logic [127:0]       tag_sum_s;

  poly1305_block_fmt u_fmt (
    .data      (in_data),
    .keep      (in_keep),
    .aad_bytes (aad_bytes_r),
    .pld_bytes (pld_bytes_r),
    .beat_m    (beat_m_s),
    .len_m     (len_m_s),
    .keep_cnt  (keep_cnt_s)
  );

  assign keep_ext_s = {{(LEN_W-5){1'b0}}, keep_cnt_s};
  // h + m can reach bit 130; 2^130 == 5 mod p folds it back into 130 bits
  assign sum_s      = {1'b0, h_r} + {2'b00, m_r};
  assign fold_s     = sum_s[129:0] + {127'd0, sum_s[130], 1'b0, sum_s[130]};
  // Only the low 128 bits of the fully reduced h reach the tag
  assign h_low_s    = (h_r >= P130) ? (h_r[127:0] - P130[127:0]) : h_r[127:0];
  assign tag_sum_s  = h_low_s + s_r;

  // Sequencer FSM with all datapath registers and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      h_r         <= 130'd0;
      r_r         <= 128'd0;
      s_r         <= 128'd0;
      aad_bytes_r <= '0;
      pld_bytes_r <= '0;
      pld_seen_r  <= 1'b0;
      blk_last_r  <= 1'b0;
      len_blk_r   <= 1'b0;
      m_r         <= 129'd0;
      in_ready_r  <= 1'b0;
      mul_start_r <= 1'b0;
      mul_a_r     <= 130'd0;
      red_start_r <= 1'b0;
      red_value_r <= 258'd0;
      tag_r       <= 128'd0;
      tag_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      mul_start_r <= 1'b0;
      red_start_r <= 1'b0;
      tag_valid_r <= 1'b0;
      err_r       <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            r_r         <= r_key & R_CLAMP;
            s_r         <= s_key;
            h_r         <= 130'd0;
            aad_bytes_r <= '0;
            pld_bytes_r <= '0;
            pld_seen_r  <= 1'b0;
            busy_r      <= 1'b1;
            in_ready_r  <= 1'b1;
            state_r     <= ST_ACCEPT;
          end
        end
        ST_ACCEPT: begin
          if (in_valid && in_ready_r) begin
            if (in_is_aad && pld_seen_r) begin
              // AAD after payload: consumed and flagged, state untouched
              err_r <= 1'b1;
            end else begin
              if (in_is_aad) begin
                aad_bytes_r <= aad_bytes_r + keep_ext_s;
              end else begin
                pld_bytes_r <= pld_bytes_r + keep_ext_s;
                pld_seen_r  <= 1'b1;
              end
              if (in_keep != 16'h0000) begin
                m_r        <= beat_m_s;
                blk_last_r <= in_last;
                len_blk_r  <= 1'b0;
                in_ready_r <= 1'b0;
                state_r    <= ST_ADD;
              end else if (in_last) begin
                in_ready_r <= 1'b0;
                state_r    <= ST_LENBLK;
              end
            end
          end
        end
        ST_LENBLK: begin
          m_r        <= len_m_s;
          len_blk_r  <= 1'b1;
          blk_last_r <= 1'b0;
          state_r    <= ST_ADD;
        end
        ST_ADD: begin
          mul_a_r     <= fold_s;
          mul_start_r <= 1'b1;
          state_r     <= ST_MUL;
        end
        ST_MUL: begin
          if (mul_done) begin
            red_value_r <= mul_product;
            red_start_r <= 1'b1;
            state_r     <= ST_RED;
          end
        end
        ST_RED: begin
          if (red_done) begin
            h_r <= red_result;
            if (len_blk_r) begin
              state_r <= ST_FINAL;
            end else if (blk_last_r) begin
              state_r <= ST_LENBLK;
            end else begin
              in_ready_r <= 1'b1;
              state_r    <= ST_ACCEPT;
            end
          end
        end
        ST_FINAL: begin
          tag_r       <= tag_sum_s;
          tag_valid_r <= 1'b1;
          busy_r      <= 1'b0;
          state_r     <= ST_IDLE;
        end
        default: begin
          in_ready_r <= 1'b0;
          busy_r     <= 1'b0;
          state_r    <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign mul_start = mul_start_r;
  assign mul_a     = mul_a_r;
  assign mul_b     = r_r;
  assign red_start = red_start_r;
  assign red_value = red_value_r;
  assign tag       = tag_r;
  assign tag_valid = tag_valid_r;
  assign busy      = busy_r;
  assign err       = err_r;

endmodule

// File: tb/tb_poly1305_block_sequencer.sv
// Bench for poly1305_block_sequencer: behavioural multiplier/reducer with
// adjustable latency, and a plain-arithmetic Poly1305 AEAD reference model.
module tb_poly1305_block_sequencer;

  localparam logic [257:0] PW     = {128'd0, 130'h3_ffffffff_ffffffff_ffffffff_fffffffb};
  localparam logic [257:0] TWO128 = 258'd1 << 128;
  localparam logic [127:0] CLAMP  = 128'h0ffffffc_0ffffffc_0ffffffc_0fffffff;

  typedef struct packed {
    logic [127:0] data;
    logic [15:0]  keep;
    logic         aad;
    logic         last;
  } beat_t;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic [127:0] r_key, s_key;
  logic         in_valid;
  logic [127:0] in_data;
  logic [15:0]  in_keep;
  logic         in_is_aad, in_last, in_ready;
  logic         mul_start, mul_done;
  logic [129:0] mul_a;
  logic [127:0] mul_b;
  logic [257:0] mul_product;
  logic         red_start, red_done;
  logic [257:0] red_value;
  logic [129:0] red_result;
  logic [127:0] tag;
  logic         tag_valid, busy, err;

  int tests_run = 0;
  int failures  = 0;
  int mul_lat   = 2;
  int red_lat   = 2;
  beat_t msg_q[$];

  always #5 clk = ~clk;

  poly1305_block_sequencer dut (
    .clk(clk), .reset_n(reset_n), .start(start), .r_key(r_key), .s_key(s_key),
    .in_valid(in_valid), .in_data(in_data), .in_keep(in_keep), .in_is_aad(in_is_aad),
    .in_last(in_last), .in_ready(in_ready), .mul_start(mul_start), .mul_a(mul_a),
    .mul_b(mul_b), .mul_product(mul_product), .mul_done(mul_done), .red_start(red_start),
    .red_value(red_value), .red_result(red_result), .red_done(red_done), .tag(tag),
    .tag_valid(tag_valid), .busy(busy), .err(err)
  );

  // Behavioural multiplier with mul_lat cycles from start to done
  logic [257:0] mul_hold;
  int           mul_cnt;
  logic         mul_busy;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mul_done <= 1'b0; mul_product <= '0; mul_hold <= '0; mul_cnt <= 0; mul_busy <= 1'b0;
    end else begin
      mul_done <= 1'b0;
      if (mul_start) begin
        mul_hold <= {128'd0, mul_a} * {130'd0, mul_b};
        mul_cnt  <= mul_lat;
        mul_busy <= 1'b1;
      end else if (mul_busy) begin
        if (mul_cnt <= 1) begin
          mul_done <= 1'b1; mul_product <= mul_hold; mul_busy <= 1'b0;
        end else begin
          mul_cnt <= mul_cnt - 1;
        end
      end
    end
  end

  // Behavioural reducer: full reduction mod 2^130-5 after red_lat cycles
  logic [257:0] red_hold;
  int           red_cnt;
  logic         red_busy;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      red_done <= 1'b0; red_result <= '0; red_hold <= '0; red_cnt <= 0; red_busy <= 1'b0;
    end else begin
      red_done <= 1'b0;
      if (red_start) begin
        red_hold <= red_value % PW;
        red_cnt  <= red_lat;
        red_busy <= 1'b1;
      end else if (red_busy) begin
        if (red_cnt <= 1) begin
          red_done <= 1'b1; red_result <= red_hold[129:0]; red_busy <= 1'b0;
        end else begin
          red_cnt <= red_cnt - 1;
        end
      end
    end
  end

  // Event monitor: err pulses, mul_start pulses, mul_a stability and in_ready during multiply
  int           err_seen = 0, mstart_seen = 0, stab_viol = 0, rdy_viol = 0;
  logic [129:0] mul_a_hold = '0;
  logic         in_mul = 1'b0;
  always @(negedge clk) begin
    if (err === 1'b1) err_seen <= err_seen + 1;
    if (mul_start === 1'b1) begin
      mstart_seen <= mstart_seen + 1;
      mul_a_hold  <= mul_a;
      in_mul      <= 1'b1;
    end else if (in_mul) begin
      if (mul_a !== mul_a_hold) stab_viol <= stab_viol + 1;
      if (in_ready !== 1'b0) rdy_viol <= rdy_viol + 1;
      if (mul_done === 1'b1 || reset_n !== 1'b1) in_mul <= 1'b0;
    end
  end

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [15:0] keep_of(input int n);
    logic [16:0] k;
    k = (17'd1 << n) - 17'd1;
    return k[15:0];
  endfunction

  // Reference: RFC 8439 AEAD Poly1305 over msg_q, one 16-byte block per non-empty beat
  function automatic logic [127:0] model_tag(input logic [127:0] rk, input logic [127:0] sk,
                                             output int n_err);
    logic [257:0] h, m, rc;
    logic [63:0]  na, np;
    logic         seen;
    int           nb;
    h = '0; na = '0; np = '0; seen = 1'b0; n_err = 0;
    rc = {130'd0, rk & CLAMP};
    foreach (msg_q[i]) begin
      if (msg_q[i].aad && seen) begin
        n_err++;
      end else begin
        nb = 0; m = '0;
        for (int b = 0; b < 16; b++) begin
          if (msg_q[i].keep[b]) begin
            nb++;
            m[b*8 +: 8] = msg_q[i].data[b*8 +: 8];
          end
        end
        if (msg_q[i].aad) na += 64'(nb);
        else begin np += 64'(nb); seen = 1'b1; end
        if (nb != 0) h = ((h + m + TWO128) * rc) % PW;
        if (msg_q[i].last) break;
      end
    end
    m = {130'd0, np, na};
    h = ((h + m + TWO128) * rc) % PW;
    return h[127:0] + sk;
  endfunction

  // Build msg_q from AAD and payload byte counts, optionally with a leading empty AAD beat
  task automatic gen_msg(input int n_aad, input int n_pld);
    beat_t b;
    int    rem, n;
    msg_q.delete();
    if ($urandom_range(0, 3) == 0) begin
      b = '{data: rand128(), keep: 16'h0000, aad: 1'b1, last: 1'b0};
      msg_q.push_back(b);
    end
    rem = n_aad;
    while (rem > 0) begin
      n = (rem > 16) ? 16 : rem;
      b = '{data: rand128(), keep: keep_of(n), aad: 1'b1, last: 1'b0};
      msg_q.push_back(b); rem -= n;
    end
    rem = n_pld;
    while (rem > 0) begin
      n = (rem > 16) ? 16 : rem;
      b = '{data: rand128(), keep: keep_of(n), aad: 1'b0, last: 1'b0};
      msg_q.push_back(b); rem -= n;
    end
    if (msg_q.size() == 0) begin
      b = '{data: rand128(), keep: 16'h0000, aad: 1'b0, last: 1'b1};
      msg_q.push_back(b);
    end else begin
      b = msg_q.pop_back(); b.last = 1'b1; msg_q.push_back(b);
    end
  endtask

  task automatic do_start(input logic [127:0] rk, input logic [127:0] sk);
    start = 1'b1; r_key = rk; s_key = sk;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_beat(input beat_t b);
    int t;
    t = 0;
    in_valid = 1'b1; in_data = b.data; in_keep = b.keep; in_is_aad = b.aad; in_last = b.last;
    while (in_ready !== 1'b1 && t < 5000) begin
      @(negedge clk); t++;
    end
    if (t >= 5000) begin
      tests_run++; failures++;
      $display("FAIL beat_accept_timeout: in_ready=%b, required 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_tag(output logic [127:0] t, output logic ok);
    int n;
    n = 0; ok = 1'b0; t = '0;
    while (n < 20000) begin
      @(negedge clk);
      if (tag_valid === 1'b1) begin
        t = tag; ok = 1'b1; break;
      end
      n++;
    end
  endtask

  task automatic run_msg(input logic [127:0] rk, input logic [127:0] sk,
                         output logic [127:0] t, output logic ok);
    do_start(rk, sk);
    foreach (msg_q[i]) send_beat(msg_q[i]);
    wait_tag(t, ok);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; r_key = '0; s_key = '0;
    in_valid = 1'b0; in_data = '0; in_keep = '0; in_is_aad = 1'b0; in_last = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({in_ready, mul_start, red_start, tag_valid, busy, err} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b, required 000000",
               {in_ready, mul_start, red_start, tag_valid, busy, err});
    end
    tests_run++;
    if ({mul_a, mul_b, red_value, tag} !== '0) begin
      failures++; $display("FAIL reset_data: got nonzero datapath outputs, required 0");
    end
    reset_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      failures++; $display("FAIL idle_after_reset: busy=%b in_ready=%b, required 0 0", busy, in_ready);
    end
  endtask

  task automatic test_empty();
    logic [127:0] t; logic ok; logic [127:0] s;
    s = 128'h0123456789abcdef0011223344556677;
    msg_q.delete();
    msg_q.push_back('{data: rand128(), keep: 16'h0000, aad: 1'b0, last: 1'b1});
    run_msg(128'd1, s, t, ok);
    tests_run++;
    if (!ok) begin failures++; $display("FAIL empty_tag: timeout, required %h", s); end
    else if (t !== s) begin failures++; $display("FAIL empty_tag: got %h required %h", t, s); end
    @(negedge clk);
    tests_run++;
    if (tag_valid !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL tag_valid_pulse: tag_valid=%b busy=%b, required 0 0", tag_valid, busy);
    end
  endtask

  task automatic test_partial();
    logic [127:0] t; logic ok;
    msg_q.delete();
    msg_q.push_back('{data: {128{1'b1}}, keep: 16'h0001, aad: 1'b0, last: 1'b1});
    run_msg(128'd1, 128'd0, t, ok);
    tests_run++;
    if (!ok || t !== 128'h0000000000000001_00000000000000ff) begin
      failures++; $display("FAIL partial_tag: got %h ok=%b required 000000000000000100000000000000ff", t, ok);
    end
  endtask

  // AAD of 12 bytes and a 114-byte payload, as in the RFC AEAD example
  task automatic test_rfc_shape(input string name);
    logic [127:0] t, exp, rk, sk; logic ok; int ne, e0;
    beat_t b;
    msg_q.delete();
    b = '{data: {32'd0, 96'hc7c6c5c4_c3c2c1c0_53525150}, keep: 16'h0fff, aad: 1'b1, last: 1'b0};
    msg_q.push_back(b);
    for (int i = 0; i < 7; i++) begin
      b = '{data: rand128(), keep: 16'hffff, aad: 1'b0, last: 1'b0};
      msg_q.push_back(b);
    end
    b = '{data: rand128(), keep: 16'h0003, aad: 1'b0, last: 1'b1};
    msg_q.push_back(b);
    rk = rand128(); sk = rand128();
    exp = model_tag(rk, sk, ne);
    e0 = err_seen;
    run_msg(rk, sk, t, ok);
    tests_run++;
    if (!ok || t !== exp) begin
      failures++; $display("FAIL %s: tag %h ok=%b required %h", name, t, ok, exp);
    end
    @(negedge clk);
    tests_run++;
    if (err_seen - e0 != ne) begin
      failures++; $display("FAIL %s_err: %0d err pulses, required %0d", name, err_seen - e0, ne);
    end
  endtask

  task automatic test_random();
    logic [127:0] t, exp, rk, sk; logic ok; int ne, e0;
    for (int k = 0; k < 6; k++) begin
      mul_lat = int'($urandom_range(1, 6));
      red_lat = int'($urandom_range(1, 6));
      gen_msg(int'($urandom_range(0, 40)), int'($urandom_range(0, 80)));
      rk = rand128(); sk = rand128();
      exp = model_tag(rk, sk, ne);
      e0 = err_seen;
      run_msg(rk, sk, t, ok);
      tests_run++;
      if (!ok || t !== exp) begin
        failures++; $display("FAIL random_tag[%0d]: got %h ok=%b required %h", k, t, ok, exp);
      end
      @(negedge clk);
      tests_run++;
      if (err_seen - e0 != ne) begin
        failures++; $display("FAIL random_err[%0d]: %0d err pulses, required %0d", k, err_seen - e0, ne);
      end
    end
    mul_lat = 2; red_lat = 2;
  endtask

  task automatic test_ordering();
    logic [127:0] t1, t2, exp, rk, sk, d0, d1; logic ok1, ok2; int ne, e0;
    rk = rand128(); sk = rand128(); d0 = rand128(); d1 = rand128();
    msg_q.delete();
    msg_q.push_back('{data: d0, keep: 16'hffff, aad: 1'b0, last: 1'b0});
    msg_q.push_back('{data: rand128(), keep: 16'h00ff, aad: 1'b1, last: 1'b0});
    msg_q.push_back('{data: d1, keep: 16'h001f, aad: 1'b0, last: 1'b1});
    exp = model_tag(rk, sk, ne);
    e0 = err_seen;
    run_msg(rk, sk, t1, ok1);
    @(negedge clk);
    tests_run++;
    if (err_seen - e0 != 1) begin
      failures++; $display("FAIL order_err: %0d err cycles, required 1", err_seen - e0);
    end
    tests_run++;
    if (!ok1 || t1 !== exp) begin
      failures++; $display("FAIL order_tag: got %h ok=%b required %h", t1, ok1, exp);
    end
    msg_q.delete();
    msg_q.push_back('{data: d0, keep: 16'hffff, aad: 1'b0, last: 1'b0});
    msg_q.push_back('{data: d1, keep: 16'h001f, aad: 1'b0, last: 1'b1});
    run_msg(rk, sk, t2, ok2);
    tests_run++;
    if (!ok2 || t1 !== t2) begin
      failures++; $display("FAIL order_vs_clean: got %h clean run %h ok=%b", t1, t2, ok2);
    end
  endtask

  task automatic test_start_while_busy();
    logic [127:0] t, exp, rk, sk; logic ok; int ne;
    rk = rand128(); sk = rand128();
    gen_msg(5, 20);
    exp = model_tag(rk, sk, ne);
    do_start(rk, sk);
    tests_run++;
    if (busy !== 1'b1) begin failures++; $display("FAIL busy_high: got %b required 1", busy); end
    do_start(rand128(), rand128());
    foreach (msg_q[i]) send_beat(msg_q[i]);
    wait_tag(t, ok);
    tests_run++;
    if (!ok || t !== exp) begin
      failures++; $display("FAIL start_ignored: got %h ok=%b required %h", t, ok, exp);
    end
  endtask

  task automatic test_stall();
    logic [127:0] t, exp, rk, sk; logic ok; int ne, m0, sv0, rv0;
    mul_lat = 200;
    rk = rand128(); sk = rand128();
    msg_q.delete();
    msg_q.push_back('{data: rand128(), keep: 16'hffff, aad: 1'b0, last: 1'b0});
    msg_q.push_back('{data: rand128(), keep: 16'h0fff, aad: 1'b0, last: 1'b1});
    exp = model_tag(rk, sk, ne);
    m0 = mstart_seen; sv0 = stab_viol; rv0 = rdy_viol;
    do_start(rk, sk);
    send_beat(msg_q[0]);
    repeat (100) @(negedge clk);
    tests_run++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_ready: got %b required 0", in_ready); end
    tests_run++;
    if (mstart_seen - m0 != 1) begin
      failures++; $display("FAIL stall_single_start: %0d mul_start pulses, required 1", mstart_seen - m0);
    end
    send_beat(msg_q[1]);
    wait_tag(t, ok);
    @(negedge clk);
    tests_run++;
    if (stab_viol != sv0 || rdy_viol != rv0) begin
      failures++; $display("FAIL stall_stable: %0d mul_a changes, %0d in_ready highs, required 0 0",
                           stab_viol - sv0, rdy_viol - rv0);
    end
    tests_run++;
    if (!ok || t !== exp) begin failures++; $display("FAIL stall_tag: got %h ok=%b required %h", t, ok, exp); end
    mul_lat = 2;
  endtask

  task automatic test_back_to_back();
    logic [127:0] t, exp, rk, sk; logic ok; int ne;
    for (int k = 0; k < 2; k++) begin
      gen_msg(int'($urandom_range(0, 20)), int'($urandom_range(1, 40)));
      rk = rand128(); sk = rand128();
      exp = model_tag(rk, sk, ne);
      run_msg(rk, sk, t, ok);
      tests_run++;
      if (!ok || t !== exp) begin
        failures++; $display("FAIL b2b_tag[%0d]: got %h ok=%b required %h", k, t, ok, exp);
      end
    end
  endtask

  task automatic test_reset_mid_mul();
    int n;
    mul_lat = 50;
    msg_q.delete();
    msg_q.push_back('{data: rand128(), keep: 16'hffff, aad: 1'b0, last: 1'b1});
    do_start(rand128(), rand128());
    send_beat(msg_q[0]);
    n = 0;
    while (mul_start !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    tests_run++;
    if (n >= 100) begin failures++; $display("FAIL mul_start_seen: mul_start=%b, required 1", mul_start); end
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    tests_run++;
    if ({in_ready, mul_start, red_start, tag_valid, busy, err} !== 6'b0 ||
        {mul_a, mul_b, red_value, tag} !== '0) begin
      failures++; $display("FAIL reset_mid_mul: outputs nonzero (busy=%b mul_b=%h), required all 0", busy, mul_b);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    mul_lat = 3;
    test_rfc_shape("rerun_after_reset");
    mul_lat = 2;
  endtask

  initial begin
    test_reset();
    test_empty();
    test_partial();
    test_rfc_shape("rfc_shape");
    test_random();
    test_ordering();
    test_start_while_busy();
    test_stall();
    test_back_to_back();
    test_reset_mid_mul();
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
